// File: rtl/pc_fetch_reg_pkg.sv
// Shared definitions for the program-counter fetch stage: default geometry
// and the fetch FSM state encoding.
package pc_fetch_reg_pkg;

    localparam int          WIDTH_DEF    = 32;
    localparam int          STEP_DEF     = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_reg_pc_adder.sv
// Constant-increment adder producing the sequential fetch address.
// The carry-out is dropped so the address wraps modulo 2^WIDTH.
module pc_adder
    import pc_fetch_reg_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEP  = STEP_DEF
) (
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] seq_pc
);

    assign seq_pc = pc + WIDTH'(STEP);

endmodule

// File: rtl/pc_fetch_reg.sv
// Program-counter register stage: holds the fetch address, offers it to
// instruction memory over valid/ready, and buffers redirects seen during stalls.
module pc_fetch_reg
    import pc_fetch_reg_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
    parameter int               STEP     = STEP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] next_pc,
    input  logic             redirect,
    output logic [WIDTH-1:0] seq_pc,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    input  logic             pc_ready,
    output logic             pc_misaligned,
    output logic [31:0]      fetch_count
);

    fetch_state_e     state_r, state_s;
    logic [WIDTH-1:0] pc_r, pc_s;
    logic             pc_valid_r, pc_valid_s;
    logic             pend_r, pend_s;
    logic [WIDTH-1:0] pend_tgt_r, pend_tgt_s;
    logic [31:0]      fetch_count_r, fetch_count_s;
    logic             handshake_s;

    pc_adder #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_pc_adder (
        .pc     (pc_r),
        .seq_pc (seq_pc)
    );

    assign pc            = pc_r;
    assign pc_valid      = pc_valid_r;
    assign fetch_count   = fetch_count_r;
    assign pc_misaligned = pc_valid_r && (pc_r[1:0] != 2'b00);
    assign handshake_s   = pc_valid_r && pc_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; valid is asserted in every state except BOOT
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_BOOT:  state_s = ST_RUN;
            ST_RUN,
            ST_STALL: begin
                if (pc_ready) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_STALL;
                end
            end
            default:  state_s = ST_BOOT;
        endcase
        pc_valid_s = (state_s != ST_BOOT);
    end

    // Datapath next values: a same-cycle redirect beats any buffered target
    always_comb begin
        pc_s          = pc_r;
        pend_s        = pend_r;
        pend_tgt_s    = pend_tgt_r;
        fetch_count_s = fetch_count_r;
        if (handshake_s) begin
            fetch_count_s = fetch_count_r + 32'd1;
            pend_s        = 1'b0;
            if (!redirect && pend_r) begin
                pc_s = pend_tgt_r;
            end else begin
                pc_s = next_pc;
            end
        end else if (redirect) begin
            pend_s     = 1'b1;
            pend_tgt_s = next_pc;
        end else begin
            pend_s     = pend_r;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            pc_valid_r    <= 1'b0;
            pend_r        <= 1'b0;
            pend_tgt_r    <= '0;
            fetch_count_r <= 32'd0;
        end else begin
            pc_r          <= pc_s;
            pc_valid_r    <= pc_valid_s;
            pend_r        <= pend_s;
            pend_tgt_r    <= pend_tgt_s;
            fetch_count_r <= fetch_count_s;
        end
    end

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Self-checking bench for pc_fetch_reg: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch stage.
module tb_pc_fetch_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] seq_pc;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        pc_misaligned;
    logic [31:0] fetch_count;

    int compared   = 0;
    int mismatched = 0;

    // Model state: what the fetch stage should be presenting right now
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_pend;
    logic [31:0] m_tgt;
    logic [31:0] m_count;

    pc_fetch_reg dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .seq_pc        (seq_pc),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .pc_ready      (pc_ready),
        .pc_misaligned (pc_misaligned),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0000_0000;
        m_valid = 1'b0;
        m_pend  = 1'b0;
        m_tgt   = 32'h0000_0000;
        m_count = 32'd0;
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model
    // across the rising edge, and return on the following falling edge.
    task automatic step(input logic rdy, input logic rd, input logic [31:0] tgt);
        logic [31:0] np;
        np       = rd ? tgt : (m_pc + 32'd4);
        pc_ready = rdy;
        redirect = rd;
        next_pc  = np;
        #1;
        check("pc", pc, m_pc);
        check("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
        check("seq_pc", seq_pc, m_pc + 32'd4);
        check("pc_misaligned", {31'd0, pc_misaligned},
              {31'd0, m_valid && (m_pc % 32'd4 != 32'd0)});
        check("fetch_count", fetch_count, m_count);
        @(posedge clk);
        if (!m_valid) begin
            m_valid = 1'b1;
            if (rd) begin m_pend = 1'b1; m_tgt = np; end
        end else if (rdy) begin
            m_count = m_count + 32'd1;
            m_pc    = (!rd && m_pend) ? m_tgt : np;
            m_pend  = 1'b0;
        end else if (rd) begin
            m_pend = 1'b1;
            m_tgt  = np;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        pc_ready = 1'b0;
        redirect = 1'b0;
        next_pc  = 32'h0000_0000;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_pc", pc, 32'h0000_0000);
        check("reset_valid", {31'd0, pc_valid}, 32'd0);
        rst_n = 1'b1;

        // Sequential fetch from reset: one idle cycle, then 0,4,8,12
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0);
        check("seq_after_boot_pc", pc, 32'd16);
        check("seq_after_boot_cnt", fetch_count, 32'd4);

        // Redirect buffered during a three-cycle stall
        step(1'b1, 1'b1, 32'h0000_0100);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h0000_0400);
        step(1'b0, 1'b0, 32'd0);
        check("stall_hold_pc", pc, 32'h0000_0100);
        step(1'b1, 1'b0, 32'd0);
        check("buffered_redirect_pc", pc, 32'h0000_0400);

        // Two redirects while stalled: the last one wins
        step(1'b0, 1'b1, 32'h0000_0400);
        step(1'b0, 1'b1, 32'h0000_0800);
        step(1'b1, 1'b0, 32'd0);
        check("last_redirect_wins", pc, 32'h0000_0800);

        // Same-cycle redirect with handshake leaves nothing pending
        step(1'b1, 1'b1, 32'h0000_2000);
        check("direct_redirect_pc", pc, 32'h0000_2000);
        step(1'b1, 1'b0, 32'd0);
        check("no_pending_left", pc, 32'h0000_2004);

        // Address wrap and misaligned target
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        check("wrap_seq_pc", seq_pc, 32'h0000_0000);
        step(1'b1, 1'b0, 32'd0);
        check("wrap_pc", pc, 32'h0000_0000);
        step(1'b1, 1'b1, 32'h0000_0102);
        check("misaligned_flag", {31'd0, pc_misaligned}, 32'd1);
        step(1'b1, 1'b0, 32'd0);

        // Asynchronous reset mid-stall with a redirect pending
        step(1'b0, 1'b1, 32'h0000_3000);
        step(1'b0, 1'b0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 32'h0000_0000);
        check("async_rst_valid", {31'd0, pc_valid}, 32'd0);
        check("async_rst_count", fetch_count, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("pending_dropped", pc, 32'h0000_0004);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic        rdy;
            logic        rd;
            logic [31:0] tgt;
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 3) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            step(rdy, rd, tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
